// File: rtl/mem_line_arbiter_pkg.sv
// Shared constants and state type for the L1-to-memory line arbiter.
package mem_line_arbiter_pkg;

   localparam int L1_LINE_WORDS = 8;
   localparam int L1_WORD_W     = 32;
   localparam int L1_LINE_BITS  = L1_LINE_WORDS * L1_WORD_W;
   localparam int L1_LINE_OFF_W = $clog2(L1_LINE_BITS / 8);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/mem_line_arbiter_rr_arb2.sv
// Two-requester round-robin grant; the favoured-port flop moves only on advance_i.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   input  logic       advance_i,
   input  logic       served_i,
   output logic [1:0] grant_o
);

   logic favour_q;
   logic favour_d;

   always_comb begin
      grant_o = req_i;
      if (req_i == 2'b11) begin
         grant_o = favour_q ? 2'b10 : 2'b01;
      end
   end

   // After serving a port, favour the other one so neither can starve.
   assign favour_d = advance_i ? ~served_i : favour_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         favour_q <= 1'b0;
      end else begin
         favour_q <= favour_d;
      end
   end

endmodule

// File: rtl/mem_line_arbiter.sv
// Arbitrates two L1 line requesters onto one word-wide memory port and
// sequences each line as LINE_WORDS single-word transactions.
module mem_line_arbiter
   import mem_line_arbiter_pkg::*;
#(
   parameter int LINE_WORDS = L1_LINE_WORDS,
   parameter int DATA_W     = L1_WORD_W,
   parameter int ADDR_W     = 32
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [1:0]                          req_valid,
   input  logic [1:0]                          req_store,
   input  logic [1:0][ADDR_W-1:0]              req_addr,
   input  logic [1:0][LINE_WORDS*DATA_W-1:0]   req_wline,
   output logic [1:0]                          req_ack,
   output logic [1:0]                          resp_valid,
   output logic [LINE_WORDS*DATA_W-1:0]        resp_rline,
   output logic                                busy,
   output logic                                arb_mem_valid,
   output logic                                arb_mem_store,
   output logic [ADDR_W-1:0]                   arb_mem_addr,
   output logic [DATA_W-1:0]                   arb_mem_wdata,
   input  logic [DATA_W-1:0]                   mem_arb_rdata,
   input  logic                                mem_arb_valid
);

   localparam int BEAT_W = $clog2(LINE_WORDS);
   localparam int BYTE_W = $clog2(DATA_W / 8);
   localparam int OFF_W  = BEAT_W + BYTE_W;

   arb_state_t              state_q;
   logic [BEAT_W-1:0]       beat_q;
   logic [BEAT_W-1:0]       beat_d;
   logic                    grant_idx_q;
   logic                    store_q;
   logic [ADDR_W-OFF_W-1:0] tag_q;
   logic [DATA_W-1:0]       buf_q [LINE_WORDS];

   logic [1:0]              resp_valid_q;
   logic                    arb_mem_valid_q;
   logic                    arb_mem_store_q;
   logic [ADDR_W-1:0]       arb_mem_addr_q;
   logic [DATA_W-1:0]       arb_mem_wdata_q;

   logic [1:0]              grant;
   logic                    grant_idx;
   logic [DATA_W-1:0]       wword [LINE_WORDS];
   logic                    unused_addr_bits;

   rr_arb2 u_rr (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req_valid),
      .advance_i (state_q == DONE),
      .served_i  (grant_idx_q),
      .grant_o   (grant)
   );

   assign grant_idx        = grant[1];
   assign beat_d           = beat_q + BEAT_W'(1);
   assign unused_addr_bits = ^{req_addr[0][OFF_W-1:0], req_addr[1][OFF_W-1:0]};

   generate
      for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_words
         assign wword[gi] = req_wline[grant_idx][gi*DATA_W +: DATA_W];
         assign resp_rline[gi*DATA_W +: DATA_W] = (resp_valid_q != 2'b00) ? buf_q[gi] : '0;
      end
   endgenerate

   // The ack must coincide with the latch cycle, so it is decoded from the
   // current state; gating with rst_n keeps it low while reset is held.
   assign req_ack       = (rst_n && state_q == IDLE) ? grant : 2'b00;
   assign resp_valid    = resp_valid_q;
   assign busy          = (state_q != IDLE);
   assign arb_mem_valid = arb_mem_valid_q;
   assign arb_mem_store = arb_mem_store_q;
   assign arb_mem_addr  = arb_mem_addr_q;
   assign arb_mem_wdata = arb_mem_wdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         beat_q          <= '0;
         grant_idx_q     <= 1'b0;
         store_q         <= 1'b0;
         tag_q           <= '0;
         resp_valid_q    <= 2'b00;
         arb_mem_valid_q <= 1'b0;
         arb_mem_store_q <= 1'b0;
         arb_mem_addr_q  <= '0;
         arb_mem_wdata_q <= '0;
         for (int k = 0; k < LINE_WORDS; k++) begin
            buf_q[k] <= '0;
         end
      end else begin
         arb_mem_valid_q <= 1'b0;
         resp_valid_q    <= 2'b00;
         case (state_q)
            IDLE: begin
               if (req_valid != 2'b00) begin
                  grant_idx_q     <= grant_idx;
                  store_q         <= req_store[grant_idx];
                  tag_q           <= req_addr[grant_idx][ADDR_W-1:OFF_W];
                  for (int k = 0; k < LINE_WORDS; k++) begin
                     buf_q[k] <= wword[k];
                  end
                  arb_mem_valid_q <= 1'b1;
                  arb_mem_store_q <= req_store[grant_idx];
                  arb_mem_addr_q  <= {req_addr[grant_idx][ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                  arb_mem_wdata_q <= wword[0];
                  state_q         <= ISSUE;
               end
            end
            ISSUE: begin
               state_q <= WAIT;
            end
            WAIT: begin
               if (mem_arb_valid) begin
                  if (!store_q) begin
                     buf_q[beat_q] <= mem_arb_rdata;
                  end
                  if (beat_q == BEAT_W'(LINE_WORDS - 1)) begin
                     resp_valid_q[grant_idx_q] <= 1'b1;
                     state_q                   <= DONE;
                  end else begin
                     // Beat index is spliced in, so the line never carries into the tag.
                     beat_q          <= beat_d;
                     arb_mem_valid_q <= 1'b1;
                     arb_mem_addr_q  <= {tag_q, beat_d, {BYTE_W{1'b0}}};
                     arb_mem_wdata_q <= buf_q[beat_d];
                     state_q         <= ISSUE;
                  end
               end
            end
            DONE: begin
               beat_q  <= '0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Directed bench for mem_line_arbiter with a variable-latency word memory model.
module tb_mem_line_arbiter;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [1:0]        req_valid;
   logic [1:0]        req_store;
   logic [1:0][31:0]  req_addr;
   logic [1:0][255:0] req_wline;
   logic [1:0]        req_ack;
   logic [1:0]        resp_valid;
   logic [255:0]      resp_rline;
   logic              busy;
   logic              arb_mem_valid;
   logic              arb_mem_store;
   logic [31:0]       arb_mem_addr;
   logic [31:0]       arb_mem_wdata;
   logic [31:0]       mem_arb_rdata;
   logic              mem_arb_valid;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // memory model: responds lat cycles after a request, read data = address
   logic        model_valid = 1'b0;
   logic [31:0] model_rdata = 32'h0;
   logic        pend        = 1'b0;
   int          cnt         = 0;
   logic [31:0] pend_addr   = 32'h0;
   int          ovl_n       = 0;
   int          lat         = 1;
   logic        inj_valid   = 1'b0;

   assign mem_arb_valid = model_valid | inj_valid;
   assign mem_arb_rdata = inj_valid ? 32'hDEAD_BEEF : model_rdata;

   // transaction logs captured mid-cycle
   int           ack_n = 0;
   logic [1:0]   ack_vec [256];
   int           ack_cyc [256];
   int           op_n = 0;
   logic [31:0]  op_addr [256];
   logic         op_store [256];
   logic [31:0]  op_wdata [256];
   int           op_cyc [256];
   int           rsp_n = 0;
   logic [1:0]   rsp_vec [256];
   int           rsp_cyc [256];
   logic [255:0] rsp_line [256];

   mem_line_arbiter dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_store     (req_store),
      .req_addr      (req_addr),
      .req_wline     (req_wline),
      .req_ack       (req_ack),
      .resp_valid    (resp_valid),
      .resp_rline    (resp_rline),
      .busy          (busy),
      .arb_mem_valid (arb_mem_valid),
      .arb_mem_store (arb_mem_store),
      .arb_mem_addr  (arb_mem_addr),
      .arb_mem_wdata (arb_mem_wdata),
      .mem_arb_rdata (mem_arb_rdata),
      .mem_arb_valid (mem_arb_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      model_valid <= 1'b0;
      if (arb_mem_valid) begin
         if (pend) ovl_n <= ovl_n + 1;
         if (lat <= 1) begin
            model_valid <= 1'b1;
            model_rdata <= arb_mem_addr;
            pend        <= 1'b0;
         end else begin
            pend      <= 1'b1;
            cnt       <= lat - 1;
            pend_addr <= arb_mem_addr;
         end
      end else if (pend) begin
         if (cnt <= 1) begin
            model_valid <= 1'b1;
            model_rdata <= pend_addr;
            pend        <= 1'b0;
         end else begin
            cnt <= cnt - 1;
         end
      end
   end

   always @(negedge clk) begin
      if (req_ack != 2'b00) begin
         ack_vec[ack_n % 256] <= req_ack;
         ack_cyc[ack_n % 256] <= cyc;
         ack_n <= ack_n + 1;
      end
      if (arb_mem_valid) begin
         op_addr[op_n % 256]  <= arb_mem_addr;
         op_store[op_n % 256] <= arb_mem_store;
         op_wdata[op_n % 256] <= arb_mem_wdata;
         op_cyc[op_n % 256]   <= cyc;
         op_n <= op_n + 1;
      end
      if (resp_valid != 2'b00) begin
         rsp_vec[rsp_n % 256]  <= resp_valid;
         rsp_cyc[rsp_n % 256]  <= cyc;
         rsp_line[rsp_n % 256] <= resp_rline;
         rsp_n <= rsp_n + 1;
      end
   end

   task automatic launch(input int port, input logic st, input logic [31:0] addr,
                         input logic [255:0] wl, output int t);
      @(posedge clk);
      #1;
      req_store[port] = st;
      req_addr[port]  = addr;
      req_wline[port] = wl;
      req_valid[port] = 1'b1;
      t = cyc;
   endtask

   task automatic wait_done(input int port, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (req_valid[port] && req_ack[port]) begin
            @(posedge clk);
            #1;
            req_valid[port] = 1'b0;
         end else if (resp_valid != 2'b00) begin
            ok = 1'b1;
            break;
         end
      end
      #1;
   endtask

   task automatic test_reset;
      rst_n     = 1'b0;
      req_valid = 2'b00;
      req_store = 2'b00;
      req_addr  = '0;
      req_wline = '0;
      @(negedge clk);
      checks++; if (req_ack !== 2'b00) begin errors++; $display("FAIL reset_ack got %b exp 00", req_ack); end
      checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid got %b exp 00", resp_valid); end
      checks++; if (resp_rline !== 256'h0) begin errors++; $display("FAIL reset_rline got %h exp 0", resp_rline); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (arb_mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got %b exp 0", arb_mem_valid); end
      checks++; if ({arb_mem_store, arb_mem_addr, arb_mem_wdata} !== 65'h0) begin errors++;
         $display("FAIL reset_mem_fields got %b %h %h exp 0 0 0", arb_mem_store, arb_mem_addr, arb_mem_wdata); end
      req_valid = 2'b11;
      #1;
      checks++; if (req_ack !== 2'b00) begin errors++; $display("FAIL reset_ack_held got %b exp 00", req_ack); end
      req_valid = 2'b00;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      $display("reset: released at cycle %0d", cyc);
   endtask

   task automatic test_read;
      int t, a0, o0, r0;
      bit ok;
      logic [255:0] ln;
      a0 = ack_n; o0 = op_n; r0 = rsp_n;
      launch(0, 1'b0, 32'h0000_1234, 256'h0, t);
      wait_done(0, 60, ok);
      checks++; if (!ok) begin errors++; $display("FAIL read_timeout got none exp resp"); end
      checks++; if (ack_n - a0 != 1 || ack_vec[a0 % 256] !== 2'b01 || ack_cyc[a0 % 256] != t) begin errors++;
         $display("FAIL read_ack got n=%0d vec=%b cyc=%0d exp n=1 vec=01 cyc=%0d", ack_n - a0, ack_vec[a0 % 256], ack_cyc[a0 % 256], t); end
      checks++; if (op_n - o0 != 8) begin errors++; $display("FAIL read_op_count got %0d exp 8", op_n - o0); end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (op_addr[(o0 + k) % 256] !== 32'h1220 + 32'(4 * k) || op_store[(o0 + k) % 256] !== 1'b0 ||
             op_cyc[(o0 + k) % 256] != t + 1 + 2 * k) begin
            errors++;
            $display("FAIL read_op%0d got addr=%h st=%b cyc=%0d exp addr=%h st=0 cyc=%0d", k,
                     op_addr[(o0 + k) % 256], op_store[(o0 + k) % 256], op_cyc[(o0 + k) % 256], 32'h1220 + 32'(4 * k), t + 1 + 2 * k);
         end
      end
      checks++; if (rsp_n - r0 != 1 || rsp_vec[r0 % 256] !== 2'b01 || rsp_cyc[r0 % 256] != t + 17) begin errors++;
         $display("FAIL read_resp got n=%0d vec=%b cyc=%0d exp n=1 vec=01 cyc=%0d", rsp_n - r0, rsp_vec[r0 % 256], rsp_cyc[r0 % 256], t + 17); end
      ln = rsp_line[r0 % 256];
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (ln[k*32 +: 32] !== 32'h1220 + 32'(4 * k)) begin errors++;
            $display("FAIL read_word%0d got %h exp %h", k, ln[k*32 +: 32], 32'h1220 + 32'(4 * k)); end
      end
      @(negedge clk);
      checks++; if (busy !== 1'b0 || resp_valid !== 2'b00) begin errors++;
         $display("FAIL read_idle_after got busy=%b resp=%b exp 0 00", busy, resp_valid); end
      $display("read: port0 addr 00001234 ack %0d resp %0d", t, rsp_cyc[r0 % 256]);
   endtask

   task automatic test_write;
      int t, o0, r0;
      bit ok;
      logic [255:0] wl;
      for (int k = 0; k < 8; k++) wl[k*32 +: 32] = 32'hA5A5_0000 + 32'(k);
      o0 = op_n; r0 = rsp_n;
      launch(1, 1'b1, 32'h0000_4000, wl, t);
      wait_done(1, 60, ok);
      checks++; if (!ok) begin errors++; $display("FAIL write_timeout got none exp resp"); end
      checks++; if (op_n - o0 != 8) begin errors++; $display("FAIL write_op_count got %0d exp 8", op_n - o0); end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (op_addr[(o0 + k) % 256] !== 32'h4000 + 32'(4 * k) || op_store[(o0 + k) % 256] !== 1'b1 ||
             op_wdata[(o0 + k) % 256] !== 32'hA5A5_0000 + 32'(k)) begin
            errors++;
            $display("FAIL write_op%0d got addr=%h st=%b data=%h exp addr=%h st=1 data=%h", k, op_addr[(o0 + k) % 256],
                     op_store[(o0 + k) % 256], op_wdata[(o0 + k) % 256], 32'h4000 + 32'(4 * k), 32'hA5A5_0000 + 32'(k));
         end
      end
      checks++; if (rsp_n - r0 != 1 || rsp_vec[r0 % 256] !== 2'b10 || rsp_cyc[r0 % 256] != t + 17) begin errors++;
         $display("FAIL write_resp got n=%0d vec=%b cyc=%0d exp n=1 vec=10 cyc=%0d", rsp_n - r0, rsp_vec[r0 % 256], rsp_cyc[r0 % 256], t + 17); end
      checks++; if (rsp_line[r0 % 256] !== wl) begin errors++;
         $display("FAIL write_line got %h exp %h", rsp_line[r0 % 256], wl); end
      $display("write: port1 addr 00004000 ack %0d resp %0d", t, rsp_cyc[r0 % 256]);
   endtask

   task automatic test_fairness;
      int c0, a0, r0, seen;
      logic [1:0]  exp_vec;
      logic [31:0] exp_w0;
      logic [255:0] ln;
      a0 = ack_n; r0 = rsp_n; seen = 0;
      @(negedge clk);
      rst_n        = 1'b0;
      req_store    = 2'b00;
      req_addr[0]  = 32'h0000_0100;
      req_addr[1]  = 32'h0000_2000;
      req_wline    = '0;
      req_valid    = 2'b11;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      c0 = cyc;
      for (int i = 0; i < 120 && seen < 4; i++) begin
         @(negedge clk);
         if (resp_valid != 2'b00) seen++;
         if (seen == 4) req_valid = 2'b00;
      end
      req_valid = 2'b00;
      #1;
      checks++; if (ack_n - a0 != 4 || rsp_n - r0 != 4) begin errors++;
         $display("FAIL fair_counts got acks=%0d resps=%0d exp 4 4", ack_n - a0, rsp_n - r0); end
      checks++; if (ack_cyc[a0 % 256] != c0) begin errors++;
         $display("FAIL fair_first_ack got %0d exp %0d", ack_cyc[a0 % 256], c0); end
      for (int i = 0; i < 4; i++) begin
         exp_vec = (i % 2 == 0) ? 2'b01 : 2'b10;
         exp_w0  = (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_2000;
         ln      = rsp_line[(r0 + i) % 256];
         checks++;
         if (ack_vec[(a0 + i) % 256] !== exp_vec || rsp_vec[(r0 + i) % 256] !== exp_vec ||
             rsp_cyc[(r0 + i) % 256] != ack_cyc[(a0 + i) % 256] + 17) begin
            errors++;
            $display("FAIL fair_grant%0d got ack=%b resp=%b dt=%0d exp %b %b 17", i, ack_vec[(a0 + i) % 256],
                     rsp_vec[(r0 + i) % 256], rsp_cyc[(r0 + i) % 256] - ack_cyc[(a0 + i) % 256], exp_vec, exp_vec);
         end
         checks++;
         if (ln[31:0] !== exp_w0 || ln[255:224] !== exp_w0 + 32'h1C) begin errors++;
            $display("FAIL fair_line%0d got w0=%h w7=%h exp %h %h", i, ln[31:0], ln[255:224], exp_w0, exp_w0 + 32'h1C); end
         if (i > 0) begin
            checks++;
            if (ack_cyc[(a0 + i) % 256] != rsp_cyc[(r0 + i - 1) % 256] + 1) begin errors++;
               $display("FAIL fair_reaccept%0d got %0d exp %0d", i, ack_cyc[(a0 + i) % 256], rsp_cyc[(r0 + i - 1) % 256] + 1); end
         end
         $display("fair: grant %0d port %b ack %0d resp %0d", i, ack_vec[(a0 + i) % 256], ack_cyc[(a0 + i) % 256], rsp_cyc[(r0 + i) % 256]);
      end
   endtask

   task automatic test_latency3;
      int t, o0, r0, v0;
      bit ok;
      logic [255:0] ln;
      lat = 3;
      o0 = op_n; r0 = rsp_n; v0 = ovl_n;
      launch(0, 1'b0, 32'h0000_3008, 256'h0, t);
      wait_done(0, 80, ok);
      checks++; if (!ok) begin errors++; $display("FAIL lat3_timeout got none exp resp"); end
      checks++; if (ovl_n != v0) begin errors++; $display("FAIL lat3_overlap got %0d exp 0", ovl_n - v0); end
      checks++; if (op_n - o0 != 8) begin errors++; $display("FAIL lat3_op_count got %0d exp 8", op_n - o0); end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (op_cyc[(o0 + k) % 256] != t + 1 + 4 * k || op_addr[(o0 + k) % 256] !== 32'h3000 + 32'(4 * k)) begin errors++;
            $display("FAIL lat3_op%0d got cyc=%0d addr=%h exp cyc=%0d addr=%h", k, op_cyc[(o0 + k) % 256],
                     op_addr[(o0 + k) % 256], t + 1 + 4 * k, 32'h3000 + 32'(4 * k)); end
      end
      checks++; if (rsp_n - r0 != 1 || rsp_cyc[r0 % 256] != t + 33) begin errors++;
         $display("FAIL lat3_resp got n=%0d cyc=%0d exp 1 %0d", rsp_n - r0, rsp_cyc[r0 % 256], t + 33); end
      ln = rsp_line[r0 % 256];
      checks++; if (ln[31:0] !== 32'h3000 || ln[255:224] !== 32'h301C) begin errors++;
         $display("FAIL lat3_line got w0=%h w7=%h exp 00003000 0000301c", ln[31:0], ln[255:224]); end
      $display("lat3: port0 addr 00003008 ack %0d resp %0d", t, rsp_cyc[r0 % 256]);
      lat = 1;
   endtask

   task automatic test_reset_mid;
      int t, r0, o1, seen;
      bit hit, ok;
      logic [255:0] ln;
      r0 = rsp_n; seen = 0; hit = 1'b0;
      launch(0, 1'b0, 32'h0000_5000, 256'h0, t);
      for (int i = 0; i < 40 && !hit; i++) begin
         @(negedge clk);
         if (req_valid[0] && req_ack[0]) begin
            @(posedge clk);
            #1;
            req_valid[0] = 1'b0;
         end else if (arb_mem_valid) begin
            if (seen == 4) begin
               rst_n = 1'b0;
               hit   = 1'b1;
               #1;
               checks++; if (arb_mem_valid !== 1'b0 || busy !== 1'b0) begin errors++;
                  $display("FAIL rstmid_valid_busy got %b %b exp 0 0", arb_mem_valid, busy); end
               checks++; if (resp_valid !== 2'b00 || req_ack !== 2'b00 || resp_rline !== 256'h0) begin errors++;
                  $display("FAIL rstmid_resp got %b %b %h exp 00 00 0", resp_valid, req_ack, resp_rline); end
               checks++; if ({arb_mem_store, arb_mem_addr, arb_mem_wdata} !== 65'h0) begin errors++;
                  $display("FAIL rstmid_mem_fields got %b %h %h exp 0 0 0", arb_mem_store, arb_mem_addr, arb_mem_wdata); end
            end
            seen++;
         end
      end
      checks++; if (!hit) begin errors++; $display("FAIL rstmid_beat4 got %0d beats exp 5", seen); end
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      o1 = op_n;
      @(negedge clk);
      inj_valid = 1'b1;
      @(negedge clk);
      inj_valid = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      checks++; if (rsp_n != r0) begin errors++; $display("FAIL rstmid_no_resp got %0d exp 0", rsp_n - r0); end
      checks++; if (op_n != o1 || busy !== 1'b0) begin errors++;
         $display("FAIL rstmid_late_valid got ops=%0d busy=%b exp 0 0", op_n - o1, busy); end
      r0 = rsp_n;
      launch(1, 1'b0, 32'h0000_6000, 256'h0, t);
      wait_done(1, 60, ok);
      ln = rsp_line[r0 % 256];
      checks++; if (!ok || rsp_vec[r0 % 256] !== 2'b10 || rsp_cyc[r0 % 256] != t + 17) begin errors++;
         $display("FAIL rstmid_fresh_resp got ok=%0d vec=%b cyc=%0d exp 1 10 %0d", ok, rsp_vec[r0 % 256], rsp_cyc[r0 % 256], t + 17); end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (ln[k*32 +: 32] !== 32'h6000 + 32'(4 * k)) begin errors++;
            $display("FAIL rstmid_fresh_word%0d got %h exp %h", k, ln[k*32 +: 32], 32'h6000 + 32'(4 * k)); end
      end
      $display("rstmid: fresh port1 addr 00006000 ack %0d resp %0d", t, rsp_cyc[r0 % 256]);
   endtask

   task automatic test_spurious;
      int t, o0, r0, seen;
      bit ok;
      logic [255:0] ln;
      o0 = op_n; r0 = rsp_n; seen = 0; ok = 1'b0;
      launch(0, 1'b0, 32'h0000_7010, 256'h0, t);
      inj_valid = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (req_valid[0] && req_ack[0]) begin
            @(posedge clk);
            #1;
            req_valid[0] = 1'b0;
            inj_valid    = 1'b0;
         end else begin
            inj_valid = arb_mem_valid && (seen == 0 || seen == 3 || seen == 7);
            if (arb_mem_valid) seen++;
            if (resp_valid != 2'b00) begin
               ok = 1'b1;
               break;
            end
         end
      end
      inj_valid = 1'b0;
      #1;
      checks++; if (!ok || op_n - o0 != 8) begin errors++;
         $display("FAIL spur_ops got ok=%0d ops=%0d exp 1 8", ok, op_n - o0); end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (op_addr[(o0 + k) % 256] !== 32'h7000 + 32'(4 * k) || op_cyc[(o0 + k) % 256] != t + 1 + 2 * k) begin errors++;
            $display("FAIL spur_op%0d got addr=%h cyc=%0d exp %h %0d", k, op_addr[(o0 + k) % 256],
                     op_cyc[(o0 + k) % 256], 32'h7000 + 32'(4 * k), t + 1 + 2 * k); end
      end
      ln = rsp_line[r0 % 256];
      checks++; if (rsp_cyc[r0 % 256] != t + 17 || rsp_vec[r0 % 256] !== 2'b01) begin errors++;
         $display("FAIL spur_resp got cyc=%0d vec=%b exp %0d 01", rsp_cyc[r0 % 256], rsp_vec[r0 % 256], t + 17); end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (ln[k*32 +: 32] !== 32'h7000 + 32'(4 * k)) begin errors++;
            $display("FAIL spur_word%0d got %h exp %h", k, ln[k*32 +: 32], 32'h7000 + 32'(4 * k)); end
      end
      $display("spur: port0 addr 00007010 ack %0d resp %0d", t, rsp_cyc[r0 % 256]);
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_fairness();
      test_latency3();
      test_reset_mid();
      test_spurious();
      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
